// File: rtl/oled_frame_streamer_if.sv
// Byte-source and transmitter handshake bundle for the OLED frame streamer.
// master = streamer side, slave = image source / serial transmitter side.
interface oled_frame_streamer_if;
  logic [9:0] byte_counter;
  logic [7:0] pixel_data;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output byte_counter, tx_data, tx_valid,
    input  pixel_data, tx_ready
  );

  modport slave (
    input  byte_counter, tx_data, tx_valid,
    output pixel_data, tx_ready
  );
endinterface

// File: rtl/oled_frame_streamer.sv
// Walks the image source over one OLED frame, hands each byte to the transmitter
// over valid/ready, then idles for an inter-frame gap; ticks the sprite animation.
module oled_frame_streamer #(
  parameter int FRAME_BYTES      = 1024,
  parameter int READ_LATENCY     = 1,
  parameter int FRAME_GAP_CYCLES = 270000,
  parameter int FRAMES_PER_STEP  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  oled_frame_streamer_if.master  bus,
  output logic                   frame_start,
  output logic                   frame_done,
  output logic                   anim_tick,
  output logic                   busy,
  output logic [15:0]            frames_sent
);

  localparam int LAT_W  = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
  localparam int GAP_W  = (FRAME_GAP_CYCLES > 1) ? $clog2(FRAME_GAP_CYCLES) : 1;
  localparam int STEP_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  localparam logic [9:0]        LAST_BYTE = 10'(FRAME_BYTES - 1);
  localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(READ_LATENCY);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(FRAME_GAP_CYCLES - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(FRAMES_PER_STEP - 1);

  typedef enum logic [1:0] {WAIT_EN, FETCH, SEND, GAP} state_t;

  state_t            state, state_nxt;
  logic [LAT_W-1:0]  lat_cnt, lat_nxt;
  logic [GAP_W-1:0]  gap_cnt, gap_nxt;
  logic [STEP_W-1:0] step_cnt, step_nxt;
  logic [9:0]        bc_nxt;
  logic [7:0]        data_nxt;
  logic              valid_nxt, start_nxt, done_nxt, tick_nxt, busy_nxt;
  logic [15:0]       frames_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= WAIT_EN;
      lat_cnt          <= '0;
      gap_cnt          <= '0;
      step_cnt         <= '0;
      bus.byte_counter <= '0;
      bus.tx_data      <= '0;
      bus.tx_valid     <= 1'b0;
      frame_start      <= 1'b0;
      frame_done       <= 1'b0;
      anim_tick        <= 1'b0;
      busy             <= 1'b0;
      frames_sent      <= '0;
    end else begin
      state            <= state_nxt;
      lat_cnt          <= lat_nxt;
      gap_cnt          <= gap_nxt;
      step_cnt         <= step_nxt;
      bus.byte_counter <= bc_nxt;
      bus.tx_data      <= data_nxt;
      bus.tx_valid     <= valid_nxt;
      frame_start      <= start_nxt;
      frame_done       <= done_nxt;
      anim_tick        <= tick_nxt;
      busy             <= busy_nxt;
      frames_sent      <= frames_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    lat_nxt    = lat_cnt;
    gap_nxt    = gap_cnt;
    step_nxt   = step_cnt;
    bc_nxt     = bus.byte_counter;
    data_nxt   = bus.tx_data;
    valid_nxt  = bus.tx_valid;
    start_nxt  = 1'b0;
    done_nxt   = 1'b0;
    tick_nxt   = 1'b0;
    frames_nxt = frames_sent;

    case (state)
      WAIT_EN: begin
        if (enable) begin
          bc_nxt    = '0;
          lat_nxt   = '0;
          start_nxt = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        // byte_counter is held until the source's registered read settles
        if (lat_cnt == LAT_LAST) begin
          data_nxt  = bus.pixel_data;
          valid_nxt = 1'b1;
          state_nxt = SEND;
        end else begin
          lat_nxt = lat_cnt + 1'b1;
        end
      end
      SEND: begin
        if (bus.tx_ready) begin
          valid_nxt = 1'b0;
          if (bus.byte_counter == LAST_BYTE) begin
            done_nxt   = 1'b1;
            frames_nxt = frames_sent + 16'd1;
            gap_nxt    = '0;
            state_nxt  = GAP;
            if (step_cnt == STEP_LAST) begin
              step_nxt = '0;
              tick_nxt = 1'b1;
            end else begin
              step_nxt = step_cnt + 1'b1;
            end
          end else begin
            bc_nxt    = bus.byte_counter + 10'd1;
            lat_nxt   = '0;
            state_nxt = FETCH;
          end
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          if (enable) begin
            bc_nxt    = '0;
            lat_nxt   = '0;
            start_nxt = 1'b1;
            state_nxt = FETCH;
          end else begin
            state_nxt = WAIT_EN;
          end
        end else begin
          gap_nxt = gap_cnt + 1'b1;
        end
      end
      default: state_nxt = WAIT_EN;
    endcase

    busy_nxt = (state_nxt == FETCH) || (state_nxt == SEND);
  end

endmodule

// File: tb/tb_oled_frame_streamer.sv
// Directed bench for oled_frame_streamer with a 4-byte frame, 1-cycle source
// latency, 3-cycle gap and an animation step every 2 frames.
module tb_oled_frame_streamer;

  localparam int FB  = 4;
  localparam int RL  = 1;
  localparam int GAP = 3;
  localparam int FPS = 2;

  logic        clk    = 1'b0;
  logic        reset  = 1'b1;
  logic        enable = 1'b0;
  logic        frame_start, frame_done, anim_tick, busy;
  logic [15:0] frames_sent;

  oled_frame_streamer_if bus();

  oled_frame_streamer #(
    .FRAME_BYTES      (FB),
    .READ_LATENCY     (RL),
    .FRAME_GAP_CYCLES (GAP),
    .FRAMES_PER_STEP  (FPS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .bus         (bus),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .anim_tick   (anim_tick),
    .busy        (busy),
    .frames_sent (frames_sent)
  );

  always #5 clk = ~clk;

  // image source: one registered cycle of read latency
  always @(posedge clk) bus.pixel_data <= 8'hA0 + {6'b0, bus.byte_counter[1:0]};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] acc_q[$];
  int         acc_cyc_q[$];
  int         start_q[$];
  int         done_q[$];
  int         tick_q[$];
  bit         overlap_seen = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.tx_valid && bus.tx_ready) begin
        acc_q.push_back(bus.tx_data);
        acc_cyc_q.push_back(cyc);
      end
      if (frame_start) start_q.push_back(cyc);
      if (frame_done)  done_q.push_back(cyc);
      if (anim_tick)   tick_q.push_back(cyc);
      if (frame_start && frame_done) overlap_seen = 1'b1;
    end
  end

  int errors = 0;
  int checks = 0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    acc_q.delete();
    acc_cyc_q.delete();
    start_q.delete();
    done_q.delete();
    tick_q.delete();
    overlap_seen = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (done_q.size() < n && k < budget) begin
      step();
      k++;
    end
    ok = (done_q.size() >= n);
  endtask

  task automatic test_reset();
    step();
    step();
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", bus.tx_valid); end
    checks++; if (bus.byte_counter !== 10'd0) begin errors++; $display("FAIL reset_byte_counter: got %0d want 0", bus.byte_counter); end
    checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", bus.tx_data); end
    checks++; if ({frame_start, frame_done, anim_tick, busy} !== 4'b0000) begin errors++; $display("FAIL reset_pulses: got %b want 0000", {frame_start, frame_done, anim_tick, busy}); end
    checks++; if (frames_sent !== 16'd0) begin errors++; $display("FAIL reset_frames_sent: got %0d want 0", frames_sent); end
    enable = 1'b1;
    step();
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_hold_busy: got %b want 0", busy); end
    enable = 1'b0;
  endtask

  task automatic test_basic_frame();
    bit ok;
    logic [7:0] exp_b;
    clear_log();
    bus.tx_ready = 1'b1;
    reset  = 1'b0;
    enable = 1'b1;
    wait_done(1, 40, ok);
    enable = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL basic_done_timeout: frame_done count %0d want 1", done_q.size()); end
    checks++; if (acc_q.size() != FB) begin errors++; $display("FAIL basic_byte_count: got %0d want %0d", acc_q.size(), FB); end
    for (int i = 0; i < FB; i++) begin
      exp_b = 8'(8'hA0 + i);
      checks++;
      if (i >= acc_q.size() || acc_q[i] !== exp_b) begin
        errors++; $display("FAIL basic_byte%0d: got %h want %h", i, (i < acc_q.size()) ? acc_q[i] : 8'hxx, exp_b);
      end
    end
    for (int i = 1; i < FB; i++) begin
      checks++;
      if (i >= acc_cyc_q.size() || acc_cyc_q[i] - acc_cyc_q[i-1] != RL + 2) begin
        errors++; $display("FAIL basic_spacing%0d: got %0d want %0d", i, (i < acc_cyc_q.size()) ? acc_cyc_q[i] - acc_cyc_q[i-1] : -1, RL + 2);
      end
    end
    checks++; if (start_q.size() != 1) begin errors++; $display("FAIL basic_start_count: got %0d want 1", start_q.size()); end
    checks++;
    if (start_q.size() < 1 || acc_cyc_q.size() < 1 || acc_cyc_q[0] - start_q[0] != RL + 1) begin
      errors++; $display("FAIL basic_start_to_byte0: got %0d want %0d", (start_q.size() > 0 && acc_cyc_q.size() > 0) ? acc_cyc_q[0] - start_q[0] : -1, RL + 1);
    end
    checks++;
    if (done_q.size() < 1 || acc_cyc_q.size() < FB || done_q[0] != acc_cyc_q[FB-1] + 1) begin
      errors++; $display("FAIL basic_done_timing: done cycle %0d, last accept cycle %0d", (done_q.size() > 0) ? done_q[0] : -1, (acc_cyc_q.size() >= FB) ? acc_cyc_q[FB-1] : -1);
    end
    checks++; if (frames_sent !== 16'd1) begin errors++; $display("FAIL basic_frames_sent: got %0d want 1", frames_sent); end
    repeat (10) step();
    checks++; if (busy !== 1'b0 || start_q.size() != 1) begin errors++; $display("FAIL basic_idle_after: busy %b starts %0d want 0/1", busy, start_q.size()); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int k;
    logic [7:0] exp_b;
    clear_log();
    enable = 1'b1;
    k = 0;
    while (!(bus.tx_valid && bus.byte_counter == 10'd2) && k < 30) begin
      step();
      k++;
    end
    checks++; if (!(bus.tx_valid && bus.byte_counter == 10'd2)) begin errors++; $display("FAIL bp_reach_byte2: valid %b counter %0d want 1/2", bus.tx_valid, bus.byte_counter); end
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      checks++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hA2 || bus.byte_counter !== 10'd2) begin
        errors++; $display("FAIL bp_hold%0d: valid %b data %h counter %0d want 1/a2/2", i, bus.tx_valid, bus.tx_data, bus.byte_counter);
      end
    end
    bus.tx_ready = 1'b1;
    wait_done(1, 30, ok);
    enable = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL bp_done_timeout: frame_done count %0d want 1", done_q.size()); end
    checks++; if (acc_q.size() != FB) begin errors++; $display("FAIL bp_byte_count: got %0d want %0d", acc_q.size(), FB); end
    for (int i = 0; i < FB; i++) begin
      exp_b = 8'(8'hA0 + i);
      checks++;
      if (i >= acc_q.size() || acc_q[i] !== exp_b) begin
        errors++; $display("FAIL bp_byte%0d: got %h want %h", i, (i < acc_q.size()) ? acc_q[i] : 8'hxx, exp_b);
      end
    end
    checks++; if (frames_sent !== 16'd2) begin errors++; $display("FAIL bp_frames_sent: got %0d want 2", frames_sent); end
    repeat (8) step();
  endtask

  task automatic test_gap_anim();
    bit ok;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    clear_log();
    enable = 1'b1;
    wait_done(4, 120, ok);
    enable = 1'b0;
    repeat (8) step();
    checks++; if (!ok || done_q.size() != 4) begin errors++; $display("FAIL gap_done_count: got %0d want 4", done_q.size()); end
    checks++; if (start_q.size() != 4) begin errors++; $display("FAIL gap_start_count: got %0d want 4", start_q.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i + 1 >= start_q.size() || i >= done_q.size() || start_q[i+1] - done_q[i] != GAP) begin
        errors++; $display("FAIL gap_len%0d: got %0d want %0d", i, (i + 1 < start_q.size() && i < done_q.size()) ? start_q[i+1] - done_q[i] : -1, GAP);
      end
    end
    checks++; if (tick_q.size() != 2) begin errors++; $display("FAIL anim_tick_count: got %0d want 2", tick_q.size()); end
    checks++;
    if (tick_q.size() < 2 || done_q.size() < 4 || tick_q[0] != done_q[1] || tick_q[1] != done_q[3]) begin
      errors++; $display("FAIL anim_tick_timing: ticks %0d/%0d dones2/4 %0d/%0d", (tick_q.size() > 0) ? tick_q[0] : -1, (tick_q.size() > 1) ? tick_q[1] : -1, (done_q.size() > 1) ? done_q[1] : -1, (done_q.size() > 3) ? done_q[3] : -1);
    end
    checks++; if (frames_sent !== 16'd4) begin errors++; $display("FAIL gap_frames_sent: got %0d want 4", frames_sent); end
    checks++; if (overlap_seen !== 1'b0) begin errors++; $display("FAIL start_done_overlap: got %b want 0", overlap_seen); end
  endtask

  task automatic test_enable_drop();
    bit ok;
    int k;
    logic [7:0] exp_b;
    clear_log();
    enable = 1'b1;
    k = 0;
    while (!(busy && bus.byte_counter == 10'd1) && k < 20) begin
      step();
      k++;
    end
    enable = 1'b0;
    checks++; if (bus.byte_counter !== 10'd1) begin errors++; $display("FAIL drop_reach_byte1: got %0d want 1", bus.byte_counter); end
    wait_done(1, 30, ok);
    repeat (15) step();
    checks++; if (!ok) begin errors++; $display("FAIL drop_done_timeout: frame_done count %0d want 1", done_q.size()); end
    checks++; if (acc_q.size() != FB) begin errors++; $display("FAIL drop_byte_count: got %0d want %0d", acc_q.size(), FB); end
    for (int i = 2; i < FB; i++) begin
      exp_b = 8'(8'hA0 + i);
      checks++;
      if (i >= acc_q.size() || acc_q[i] !== exp_b) begin
        errors++; $display("FAIL drop_byte%0d: got %h want %h", i, (i < acc_q.size()) ? acc_q[i] : 8'hxx, exp_b);
      end
    end
    checks++; if (start_q.size() != 1 || busy !== 1'b0) begin errors++; $display("FAIL drop_no_restart: starts %0d busy %b want 1/0", start_q.size(), busy); end
    checks++; if (frames_sent !== 16'd5) begin errors++; $display("FAIL drop_frames_sent: got %0d want 5", frames_sent); end
    enable = 1'b1;
    k = 0;
    while (start_q.size() < 2 && k < 10) begin
      step();
      k++;
    end
    checks++; if (start_q.size() != 2) begin errors++; $display("FAIL drop_restart: starts %0d want 2", start_q.size()); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int k;
    logic [7:0] exp_b;
    k = 0;
    while (!(bus.tx_valid && bus.byte_counter == 10'd1) && k < 30) begin
      step();
      k++;
    end
    checks++; if (bus.tx_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_reach: valid %b want 1", bus.tx_valid); end
    bus.tx_ready = 1'b0;
    step();
    #2;
    reset = 1'b1;
    #1;
    checks++; if (bus.tx_valid !== 1'b0 || bus.byte_counter !== 10'd0) begin errors++; $display("FAIL rst_mid_immediate: valid %b counter %0d want 0/0", bus.tx_valid, bus.byte_counter); end
    checks++; if (bus.tx_data !== 8'h00 || frames_sent !== 16'd0) begin errors++; $display("FAIL rst_mid_regs: data %h frames %0d want 00/0", bus.tx_data, frames_sent); end
    checks++; if ({frame_start, frame_done, anim_tick, busy} !== 4'b0000) begin errors++; $display("FAIL rst_mid_pulses: got %b want 0000", {frame_start, frame_done, anim_tick, busy}); end
    step();
    clear_log();
    bus.tx_ready = 1'b1;
    reset = 1'b0;
    wait_done(1, 40, ok);
    enable = 1'b0;
    checks++; if (!ok || start_q.size() != 1) begin errors++; $display("FAIL rst_restart: dones %0d starts %0d want 1/1", done_q.size(), start_q.size()); end
    for (int i = 0; i < FB; i++) begin
      exp_b = 8'(8'hA0 + i);
      checks++;
      if (i >= acc_q.size() || acc_q[i] !== exp_b) begin
        errors++; $display("FAIL rst_byte%0d: got %h want %h", i, (i < acc_q.size()) ? acc_q[i] : 8'hxx, exp_b);
      end
    end
    checks++; if (frames_sent !== 16'd1) begin errors++; $display("FAIL rst_frames_sent: got %0d want 1", frames_sent); end
  endtask

  initial begin
    bus.tx_ready = 1'b1;
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_gap_anim();
    test_enable_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
